// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for the SAR search controller: start request, the
// three magnitude flags coming back, and the candidate/result outputs.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  // start is a level sampled only while the controller is idle; it is
  // neither acknowledged nor queued, so a start seen while busy or on the
  // done cycle is simply dropped. done is a one-cycle pulse, and result and
  // error are valid from that cycle until the next accepted start.
  logic             start;
  logic             a_eq_b;
  logic             a_gt_b;
  logic             a_lt_b;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             error;

  modport master (
    input  start, a_eq_b, a_gt_b, a_lt_b,
    output guess, busy, done, result, error
  );

  modport slave (
    output start, a_eq_b, a_gt_b, a_lt_b,
    input  guess, busy, done, result, error
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search: drives a candidate into an external
// comparator and resolves one bit of the unknown target per clock.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  sar_search_ctrl_if.master bus,
  output logic [1:0]        o_state
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_guess;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_error;

  logic             w_onehot;
  logic [WIDTH-1:0] w_work;
  logic [WIDTH-1:0] w_next_guess;

  // Working value keeps the trial bit only when the target is above the guess.
  always_comb begin
    w_onehot = ( bus.a_eq_b & ~bus.a_gt_b & ~bus.a_lt_b) |
               (~bus.a_eq_b &  bus.a_gt_b & ~bus.a_lt_b) |
               (~bus.a_eq_b & ~bus.a_gt_b &  bus.a_lt_b);
    w_work = r_guess;
    if (bus.a_lt_b) w_work[r_idx] = 1'b0;
    w_next_guess = w_work;
    if (r_idx != '0) w_next_guess[r_idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_guess  <= '0;
      r_idx    <= TOP_IDX;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_guess  <= MSB_ONE;
            r_idx    <= TOP_IDX;
            r_result <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_TRIAL;
          end
        end
        ST_TRIAL: begin
          if (!w_onehot) begin
            r_error  <= 1'b1;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (bus.a_eq_b) begin
            r_result <= r_guess;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (r_idx == '0) begin
            // Last bit decided by gt/lt alone; this is how target 0 resolves.
            r_result <= w_work;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_guess <= w_next_guess;
            r_idx   <= r_idx - 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.guess  = r_guess;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.error  = r_error;
  assign o_state    = r_state;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: table of searches with hand-computed
// guess sequences, plus reset and start-while-busy sequences.
module tb_sar_search_ctrl;
  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0]  target;
    int          trials;
    logic [15:0] guesses;
    logic [3:0]  result;
    logic        error;
    int          bad_trial;
    int          mid_start;
    logic        done_start;
  } vec_t;

  logic clk;
  logic rst;
  logic [WIDTH-1:0] target;
  logic force_bad;
  logic [1:0] dbg_state;

  int checks;
  int errors;
  logic [WIDTH-1:0] exp_q[$];
  vec_t vecs[9];

  sar_search_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // Comparator model; force_bad makes gt and lt assert together.
  assign bus.a_eq_b = (target == bus.guess);
  assign bus.a_gt_b = (target > bus.guess) | force_bad;
  assign bus.a_lt_b = (target < bus.guess) | force_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic run_vec(input vec_t v);
    int   edges;
    int   trial;
    logic seen_done;
    target = v.target;
    for (int i = 0; i < v.trials; i++) exp_q.push_back(v.guesses[15-4*i -: 4]);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_error_clr", bus.error, 0);
    chk("accept_result_clr", bus.result, 0);
    edges = 0;
    trial = 1;
    seen_done = 1'b0;
    while (edges <= WIDTH + 1) begin
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.busy) begin
        if (exp_q.size() == 0) chk("guess_extra", bus.guess, 'hff);
        else chk("guess", bus.guess, exp_q.pop_front());
      end
      force_bad = (trial == v.bad_trial);
      bus.start = (trial == v.mid_start);
      @(posedge clk);
      edges++;
      trial++;
      @(negedge clk);
      force_bad = 1'b0;
      bus.start = 1'b0;
    end
    chk("done_seen", seen_done, 1);
    chk("latency", edges, v.trials);
    chk("result", bus.result, v.result);
    chk("error", bus.error, v.error);
    chk("busy_at_done", bus.busy, 0);
    chk("guesses_left", exp_q.size(), 0);
    exp_q.delete();
    if (v.done_start) bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
    chk("result_held", bus.result, v.result);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    force_bad = 1'b0;
    target = '0;
    //          tgt    n  guesses   res  err bad mid dstart
    vecs[0] = '{4'd5,  4, 16'h8465, 4'd5,  0, 0, 2, 0};
    vecs[1] = '{4'd8,  1, 16'h8000, 4'd8,  0, 0, 0, 0};
    vecs[2] = '{4'd0,  4, 16'h8421, 4'd0,  0, 0, 0, 0};
    vecs[3] = '{4'd15, 4, 16'h8CEF, 4'd15, 0, 0, 0, 0};
    vecs[4] = '{4'd5,  2, 16'h8400, 4'd0,  1, 2, 0, 0};
    vecs[5] = '{4'd12, 2, 16'h8C00, 4'd12, 0, 0, 0, 0};
    vecs[6] = '{4'd10, 3, 16'h8CA0, 4'd10, 0, 0, 0, 0};
    vecs[7] = '{4'd7,  4, 16'h8467, 4'd7,  0, 0, 0, 0};
    vecs[8] = '{4'd14, 3, 16'h8CE0, 4'd14, 0, 0, 0, 1};

    // Reset held with start asserted: nothing may begin.
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_guess", bus.guess, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Last vector left start high: ignored on the done cycle, taken on the next.
    run_vec('{4'd6, 3, 16'h8460, 4'd6, 0, 0, 0, 0});

    // Reset on the second trial edge abandons the search silently.
    target = 4'd5;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_guess_before_rst", bus.guess, 4'h4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_guess", bus.guess, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_error", bus.error, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_no_done", bus.done, 0);
    chk("mid_rst_stays_idle", dbg_state, 0);
    run_vec('{4'd3, 4, 16'h8423, 4'd3, 0, 0, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation controller that drives the candidate operand of an external 2-input magnitude comparator and consumes its eq/gt/lt flags to recover an unknown WIDTH-bit value presented on the comparator's other input. It is the operand-generating end of the comparator interface: its `guess` output feeds comparator input `b`, and the unknown target drives comparator input `a`. Used on the Nexys3 lab board to read a switch-set value back through the comparator. One bit is resolved per cycle, with early termination on equality.

## Interface
- WIDTH, 4: width of target, guess and result (≥2).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- a_eq_b  in  1  comparator flag: target == guess.
- a_gt_b  in  1  comparator flag: target > guess.
- a_lt_b  in  1  comparator flag: target < guess.
- guess  out  WIDTH  registered candidate driven to comparator `b`.
- busy  out  1  high while in TRIAL.
- done  out  1  one-cycle pulse when the search ends, including on error.
- result  out  WIDTH  recovered value; held until the next accepted start.
- error  out  1  flags were not one-hot during a trial; held until the next accepted start.

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, guess=0, busy=0, done=0, result=0, error=0, bit index=WIDTH-1.
- States:
  - IDLE: waits for `start`.
  - TRIAL: one comparison per cycle.
  - DONE: one cycle; drives `done`=1, then returns to IDLE.
- IDLE→TRIAL on `start`=1:
  - guess ← 1 at bit WIDTH-1, all other bits 0.
  - index ← WIDTH-1.
  - result ← 0, error ← 0.
- TRIAL, each edge. The flags come combinationally from the registered guess and are sampled on this edge.
  - Flags not exactly one-hot (none set, or more than one set): error ← 1, result ← 0, go to DONE.
  - a_eq_b: result ← guess, go to DONE.
  - a_lt_b: bit[index] of the working value is cleared.
  - a_gt_b: bit[index] of the working value is kept.
  - If index==0: result ← working value, go to DONE.
  - Otherwise: guess ← working value with bit[index-1] set, and index decrements.
- DONE→IDLE unconditionally. guess holds its last value.
- `start` while busy or in DONE: ignored. It is not queued.
- `rst` in any state: all registers take reset values on that edge, and the search is abandoned with no `done` pulse.
- Width rule: all arithmetic is unsigned and WIDTH bits wide. Targets 0 and 2^WIDTH-1 resolve without wrap. Target 0 is resolved by the index==0 path and never sees eq.

## Timing
- Start accepted on edge E0. The first guess is visible after E0, and its flags are sampled on E1.
- Trials occur on E1..Ek, where k ≤ WIDTH. k<WIDTH only when eq is seen early.
- busy is high for cycles E0+..Ek. done is high for exactly one cycle after Ek. result and error are valid from that same cycle.
- Maximum latency from start edge to done: WIDTH+1 edges. A new start is accepted at the earliest on the edge after done.
- Comparator path is combinational. Its settle time (guess register → flags → FSM) fits in one clk period.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → guess=0, busy=0, done=0, result=0, error=0; no search begins.
- WIDTH=4, target=5, start pulse:
  - guess sequence 1000, 0100, 0110, 0101.
  - eq on the 4th trial → done pulse 5 edges after start, result=0101, error=0.
- WIDTH=4, boundary targets:
  - target=8: eq on the first trial → done 2 edges after start, result=1000.
  - target=0: guesses 1000, 0100, 0010, 0001, all lt → result=0000.
  - target=15: guesses 1000, 1100, 1110, 1111 → result=1111.
- Illegal flags: force a_gt_b=a_lt_b=1 on the 2nd trial → error=1, result=0, done pulse on the next cycle; the next start clears error.
- Start during busy: start pulsed mid-search with target=5 → no restart, result=5 delivered at the normal time; a start on the done cycle is ignored, and a start on the following cycle is accepted.
- Reset mid-operation: rst asserted on the 2nd trial edge → IDLE with all reset values, no done pulse; a new start with target=3 → result=0011.
